dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
// - Shares the single-port data memory between the CPU load/store path and the UART program/data loader.
// - Sits between the CPU data port and Data_Mamory.
// - Sequences every access as request -> memory cycle -> one-cycle ack.
// - Round-robin tie-break; stalls the CPU while the loader owns the port.
// PARAMETERS
// - ADDR_WIDTH  14         word-address bits driven to the memory
// - DATA_WIDTH  `REGWIDTH  data word width (32)
// PORTS
// - clk          in   1           rising-edge clock, single clock domain
// - rst          in   1           synchronous, active-low reset
// - cpu_req      in   1           CPU access request; held with payload until cpu_ack
// - cpu_we       in   1           1 = store, 0 = load
// - cpu_addr     in   ADDR_WIDTH  CPU word address
// - cpu_wdata    in   DATA_WIDTH  store data
// - cpu_rdata    out  DATA_WIDTH  load data; valid in the cpu_ack cycle, held until the next CPU ack
// - cpu_ack      out  1           one-cycle completion pulse
// - cpu_stall    out  1           cpu_req & ~cpu_ack (combinational)
// - ld_req       in   1           loader write request; held with payload until ld_ack
// - ld_addr      in   ADDR_WIDTH  loader word address
// - ld_wdata     in   DATA_WIDTH  loader write data (loader is write-only)
// - ld_ack       out  1           one-cycle completion pulse
// - mem_en       out  1           memory enable
// - mem_we       out  1           memory write enable
// - mem_addr     out  ADDR_WIDTH  memory address
// - mem_wdata    out  DATA_WIDTH  memory write data
// - mem_rdata    in   DATA_WIDTH  memory read data; synchronous, valid one cycle after mem_en
// - proto_err    out  1           sticky: a requester dropped req before its ack
// BEHAVIOUR
// - Reset values (rst==0 at a clock edge):
//   - state = IDLE; all outputs 0; cpu_rdata = 0
//   - last_grant = LD, so the first tie goes to the CPU
// - FSM states: IDLE -> BUSY -> RESP -> IDLE.
// - IDLE, cycle T:
//   - If any req is high, pick the owner and register owner, we, addr and wdata.
//   - Next state BUSY at T+1.
// - Owner selection in IDLE:
//   - Only one req high: that requester owns.
//   - Both high: the requester not equal to last_grant owns.
//   - last_grant updates on each grant.
// - BUSY (T+1):
//   - mem_en = 1; mem_we = registered we (loader always 1).
//   - mem_addr and mem_wdata come from the registers, not live inputs.
// - RESP (T+2):
//   - Owner's ack = 1 for exactly one cycle.
//   - CPU load: cpu_rdata <= mem_rdata on the T+2 edge, visible in the ack cycle.
//   - Next state IDLE.
// - Latency and throughput:
//   - Ack arrives 2 cycles after the sampling edge.
//   - One access per 3 cycles; back-to-back req is re-arbitrated in IDLE.
// - Requester rule: drop req the cycle after ack or keep it for the next access.
// - Non-owner req is ignored until the next IDLE; no request is lost or reordered.
// - Req dropped during BUSY/RESP:
//   - The access still completes and ack still pulses.
//   - proto_err sets and clears only on reset.
// - Reset during BUSY:
//   - mem_en and mem_we are gated with rst, so no write commits in that cycle.
//   - No ack is issued; state returns to IDLE.
// - Reset during RESP: ack is suppressed.
// - The arbiter never drives both acks in the same cycle.
// - mem_en is never high outside BUSY.
// STRUCTURE
// - variables.v gains `ARB_IDLE / `ARB_BUSY / `ARB_RESP state encodings (2 bits).
// - variables.v gains `GNT_CPU / `GNT_LD.
// - ADDR_WIDTH default moves into variables.v as `DMEM_AWIDTH.
// - One sub-module: rr_arb2.
//   - Inputs: 2 requests, last_grant. Output: grant.
//   - Combinational; last_grant is stored in the parent.
// - Parent holds the FSM, payload registers, rdata register and proto_err.
// TESTING
// - Reset: hold rst=0 3 cycles with both reqs high -> mem_en=0, acks=0, cpu_rdata=0, state IDLE.
// - CPU store then load:
//   - Store addr 0x010, data 0xDEADBEEF -> mem_we=1 at T+1, cpu_ack at T+2.
//   - Load 0x010 -> cpu_rdata=0xDEADBEEF in its ack cycle.
// - Tie:
//   - Both reqs high from reset -> CPU granted first.
//   - Next IDLE -> loader, then CPU; acks alternate, never coincide.
//   - cpu_stall=1 throughout the loader's window.
// - Loader burst: 8 writes to addrs 0..7 with no CPU req -> 8 ld_acks, one every 3 cycles; CPU reads back all 8.
// - Protocol error: CPU drops req in BUSY -> cpu_ack still pulses at T+2, proto_err=1 until reset.
// - Reset in BUSY of a loader write to 0x020 holding 0x12345678 -> no mem_we pulse; later read of 0x020 returns its old value.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// rtl/dmem_port_arbiter_pkg.sv - shared widths, FSM encoding and grant encoding for the data-memory port arbiter
package dmem_port_arbiter_pkg;

   localparam int DMEM_AWIDTH = 14;
   localparam int REGWIDTH    = 32;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_t;

   typedef enum logic {
      GNT_CPU = 1'b0,
      GNT_LD  = 1'b1
   } gnt_t;

   function automatic gnt_t other_gnt(input gnt_t g);
      return (g == GNT_CPU) ? GNT_LD : GNT_CPU;
   endfunction

endpackage

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// rtl/dmem_port_arbiter_rr_arb2.sv - two-way round-robin pick; last grant is held by the parent
module dmem_port_arbiter_rr_arb2
   import dmem_port_arbiter_pkg::*;
(
   input  logic i_req_cpu,
   input  logic i_req_ld,
   input  gnt_t i_last_grant,
   output gnt_t o_grant
);

   // With no request the result is unused; CPU is just a stable default.
   always_comb begin
      o_grant = GNT_CPU;
      if (i_req_cpu && i_req_ld) begin
         o_grant = other_gnt(i_last_grant);
      end else if (i_req_ld) begin
         o_grant = GNT_LD;
      end
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares the single-port data memory between CPU and UART loader
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = DMEM_AWIDTH,
   parameter int DATA_WIDTH = REGWIDTH
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_ack,
   output logic                  cpu_stall,
   input  logic                  ld_req,
   input  logic [ADDR_WIDTH-1:0] ld_addr,
   input  logic [DATA_WIDTH-1:0] ld_wdata,
   output logic                  ld_ack,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  proto_err
);

   arb_state_t            r_state;
   arb_state_t            w_next_state;
   gnt_t                  r_last_grant;
   gnt_t                  r_owner;
   gnt_t                  w_grant;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_proto_err;
   logic                  w_take;
   logic                  w_in_flight;
   logic                  w_owner_req;
   logic                  w_cpu_load_resp;

   dmem_port_arbiter_rr_arb2 u_rr_arb2 (
      .i_req_cpu    (cpu_req),
      .i_req_ld     (ld_req),
      .i_last_grant (r_last_grant),
      .o_grant      (w_grant)
   );

   assign w_take          = (r_state == ARB_IDLE) && (cpu_req || ld_req);
   assign w_in_flight     = (r_state == ARB_BUSY) || (r_state == ARB_RESP);
   assign w_owner_req     = (r_owner == GNT_CPU) ? cpu_req : ld_req;
   assign w_cpu_load_resp = (r_state == ARB_RESP) && (r_owner == GNT_CPU) && !r_we && rst;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Memory strobes and acks are gated with rst so a reset mid-access commits nothing.
   always_comb begin
      w_next_state = r_state;
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      cpu_ack      = 1'b0;
      ld_ack       = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (w_take) begin
               w_next_state = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            mem_en       = rst;
            mem_we       = r_we && rst;
            mem_addr     = r_addr;
            mem_wdata    = r_wdata;
            w_next_state = ARB_RESP;
         end
         ARB_RESP: begin
            cpu_ack      = rst && (r_owner == GNT_CPU);
            ld_ack       = rst && (r_owner == GNT_LD);
            w_next_state = ARB_IDLE;
         end
         default: begin
            w_next_state = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_owner      <= GNT_CPU;
         r_last_grant <= GNT_LD;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_rdata      <= '0;
         r_proto_err  <= 1'b0;
      end else begin
         if (w_take) begin
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
            r_we         <= (w_grant == GNT_CPU) ? cpu_we : 1'b1;
            r_addr       <= (w_grant == GNT_CPU) ? cpu_addr : ld_addr;
            r_wdata      <= (w_grant == GNT_CPU) ? cpu_wdata : ld_wdata;
         end
         if (w_cpu_load_resp) begin
            r_rdata <= mem_rdata;
         end
         if (w_in_flight && !w_owner_req) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   // Memory data is only valid in the ack cycle, so it bypasses the hold register there.
   assign cpu_rdata = w_cpu_load_resp ? mem_rdata : r_rdata;
   assign cpu_stall = cpu_req && !cpu_ack;
   assign proto_err = r_proto_err;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - directed self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req;
   logic        cpu_we;
   logic [13:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_ack;
   logic        cpu_stall;
   logic        ld_req;
   logic [13:0] ld_addr;
   logic [31:0] ld_wdata;
   logic        ld_ack;
   logic        mem_en;
   logic        mem_we;
   logic [13:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic        proto_err;

   logic [31:0] mem [0:16383];
   int          we_pulses = 0;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   dmem_port_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ack   (cpu_ack),
      .cpu_stall (cpu_stall),
      .ld_req    (ld_req),
      .ld_addr   (ld_addr),
      .ld_wdata  (ld_wdata),
      .ld_ack    (ld_ack),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .proto_err (proto_err)
   );

   // synchronous read-first single-port memory
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         mem_rdata <= mem[mem_addr];
      end
   end

   always @(negedge clk) begin
      if (mem_en && mem_we) we_pulses++;
   end

   task automatic cpu_access(input logic we, input logic [13:0] a, input logic [31:0] d,
                             output int lat, output int we_cyc, output logic [31:0] rd);
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      lat = 0; we_cyc = 0; rd = '0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (mem_en && mem_we && we_cyc == 0) we_cyc = lat;
         if (cpu_ack) break;
      end
      rd = cpu_rdata;
      @(posedge clk); #1;
      cpu_req = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; cpu_req = 1'b1; ld_req = 1'b1; cpu_we = 1'b1;
      cpu_addr = 14'h001; cpu_wdata = 32'h1; ld_addr = 14'h002; ld_wdata = 32'h2;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
      checks++; if (cpu_ack !== 1'b0 || ld_ack !== 1'b0) begin errors++; $display("FAIL reset_acks: got %b%b want 00", cpu_ack, ld_ack); end
      checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_cpu_rdata: got %h want 0", cpu_rdata); end
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
      @(posedge clk); #1;
      cpu_req = 1'b0; ld_req = 1'b0; rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_idle_mem_en: got %b want 0", mem_en); end
   endtask

   task automatic test_store_load();
      int lat; int we_cyc; logic [31:0] rd;
      cpu_access(1'b1, 14'h010, 32'hDEADBEEF, lat, we_cyc, rd);
      checks++; if (lat !== 3) begin errors++; $display("FAIL store_latency: got %0d want 3", lat); end
      checks++; if (we_cyc !== 2) begin errors++; $display("FAIL store_mem_we_cycle: got %0d want 2", we_cyc); end
      cpu_access(1'b0, 14'h010, 32'h0, lat, we_cyc, rd);
      checks++; if (lat !== 3) begin errors++; $display("FAIL load_latency: got %0d want 3", lat); end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata: got %h want deadbeef", rd); end
      checks++; if (we_cyc !== 0) begin errors++; $display("FAIL load_no_write: got write at cycle %0d want none", we_cyc); end
      repeat (2) @(negedge clk);
      checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata_held: got %h want deadbeef", cpu_rdata); end
   endtask

   task automatic test_tie();
      int   n; int cpu_n; int ld_n;
      int   cyc [3];
      logic who [3];
      logic both; logic stall_gap;
      n = 0; cpu_n = 0; ld_n = 0; both = 1'b0; stall_gap = 1'b0;
      for (int i = 0; i < 3; i++) begin cyc[i] = 0; who[i] = 1'b0; end
      @(posedge clk); #1;
      rst = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h030; cpu_wdata = 32'hA5A50001;
      ld_req = 1'b1; ld_addr = 14'h031; ld_wdata = 32'h5A5A0002;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (k >= 4 && k <= 6 && cpu_stall !== 1'b1) stall_gap = 1'b1;
         if (cpu_ack && ld_ack) both = 1'b1;
         if (cpu_ack || ld_ack) begin
            if (n < 3) begin who[n] = ld_ack; cyc[n] = k; end
            n++;
         end
         if (cpu_ack) cpu_n++;
         if (ld_ack) ld_n++;
         @(posedge clk); #1;
         if (cpu_n >= 2) cpu_req = 1'b0;
         if (ld_n >= 1) ld_req = 1'b0;
      end
      checks++; if (n !== 3) begin errors++; $display("FAIL tie_ack_count: got %0d want 3", n); end
      checks++; if (who[0] !== 1'b0) begin errors++; $display("FAIL tie_first_owner: got ld=%b want cpu", who[0]); end
      checks++; if (who[1] !== 1'b1) begin errors++; $display("FAIL tie_second_owner: got ld=%b want ld", who[1]); end
      checks++; if (who[2] !== 1'b0) begin errors++; $display("FAIL tie_third_owner: got ld=%b want cpu", who[2]); end
      checks++; if (cyc[0] !== 3 || cyc[1] !== 6 || cyc[2] !== 9) begin
         errors++; $display("FAIL tie_ack_cycles: got %0d,%0d,%0d want 3,6,9", cyc[0], cyc[1], cyc[2]);
      end
      checks++; if (both !== 1'b0) begin errors++; $display("FAIL tie_acks_coincide: got 1 want 0"); end
      checks++; if (stall_gap !== 1'b0) begin errors++; $display("FAIL tie_cpu_stall: got stall low in loader window want high"); end
   endtask

   task automatic test_ld_burst();
      int n; int k; int last; int first; int bad_gap; int lat; int we_cyc; logic [31:0] rd; logic spurious;
      n = 0; k = 0; last = 0; first = 0; bad_gap = 0; spurious = 1'b0;
      @(posedge clk); #1;
      ld_req = 1'b1; ld_addr = 14'h000; ld_wdata = 32'h10000000;
      while (n < 8 && k < 60) begin
         @(negedge clk);
         k++;
         if (cpu_ack) spurious = 1'b1;
         if (ld_ack) begin
            if (n == 0) first = k;
            else if (k - last != 3) bad_gap++;
            last = k;
            n++;
            @(posedge clk); #1;
            if (n == 8) ld_req = 1'b0;
            else begin ld_addr = 14'(n); ld_wdata = 32'h10000000 + 32'(n); end
         end
      end
      ld_req = 1'b0;
      checks++; if (n !== 8) begin errors++; $display("FAIL burst_ack_count: got %0d want 8", n); end
      checks++; if (first !== 3) begin errors++; $display("FAIL burst_first_latency: got %0d want 3", first); end
      checks++; if (bad_gap !== 0) begin errors++; $display("FAIL burst_spacing: got %0d bad gaps want 0", bad_gap); end
      checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL burst_spurious_cpu_ack: got 1 want 0"); end
      for (int i = 0; i < 8; i++) begin
         cpu_access(1'b0, 14'(i), 32'h0, lat, we_cyc, rd);
         checks++; if (rd !== 32'h10000000 + 32'(i) || lat !== 3) begin
            errors++; $display("FAIL burst_readback_%0d: got %h lat %0d want %h lat 3", i, rd, lat, 32'h10000000 + 32'(i));
         end
      end
   endtask

   task automatic test_proto_err();
      int k; logic got;
      k = 0; got = 1'b0;
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_err_clear_before: got %b want 0", proto_err); end
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h010;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      while (k < 10 && !got) begin
         @(negedge clk);
         k++;
         if (cpu_ack) begin
            got = 1'b1;
            checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL proto_rdata: got %h want deadbeef", cpu_rdata); end
         end
      end
      checks++; if (k !== 2 || !got) begin errors++; $display("FAIL proto_ack_still_pulses: got cycle %0d seen %b want cycle 2", k, got); end
      repeat (4) @(negedge clk);
      checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_err_sticky: got %b want 1", proto_err); end
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1; rst = 1'b1;
      @(negedge clk);
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_err_reset: got %b want 0", proto_err); end
   endtask

   task automatic test_reset_busy();
      int lat; int we_cyc; int base; int acks; logic [31:0] rd;
      acks = 0;
      cpu_access(1'b1, 14'h020, 32'hCAFE0001, lat, we_cyc, rd);
      checks++; if (lat !== 3) begin errors++; $display("FAIL rbusy_prestore_latency: got %0d want 3", lat); end
      @(posedge clk); #1;
      base = we_pulses;
      ld_req = 1'b1; ld_addr = 14'h020; ld_wdata = 32'h12345678;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rbusy_mem_gated: got en=%b we=%b want 0 0", mem_en, mem_we); end
      @(posedge clk); #1;
      ld_req = 1'b0; rst = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (ld_ack) acks++;
      end
      checks++; if (acks !== 0) begin errors++; $display("FAIL rbusy_no_ack: got %0d acks want 0", acks); end
      checks++; if (we_pulses - base !== 0) begin errors++; $display("FAIL rbusy_no_write: got %0d writes want 0", we_pulses - base); end
      cpu_access(1'b0, 14'h020, 32'h0, lat, we_cyc, rd);
      checks++; if (rd !== 32'hCAFE0001) begin errors++; $display("FAIL rbusy_old_value: got %h want cafe0001", rd); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      ld_req = 1'b0; ld_addr = '0; ld_wdata = '0;
      test_reset();
      test_store_load();
      test_tie();
      test_ld_burst();
      test_proto_err();
      test_reset_busy();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
